// File: rtl/lcd_ctrl.sv
// ============================================================================
// Module      : lcd_ctrl
// Description : HD44780-style LCD write sequencer driven from a memory-mapped
//               output-peripheral word. A toggle on bit 10 requests a write;
//               the block walks SETUP / PULSE / HOLD / WAIT with a single
//               down-counter and reports busy/done back to software.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_ctrl #(
    parameter int T_SETUP      = 2,
    parameter int T_PULSE      = 12,
    parameter int T_HOLD       = 2,
    parameter int T_WAIT_SHORT = 2000,
    parameter int T_WAIT_LONG  = 82000,
    parameter int CNT_W        = 20
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] lcd_word_i,
    output logic [7:0]  lcd_data_o,
    output logic        lcd_rs_o,
    output logic        lcd_rw_o,
    output logic        lcd_en_o,
    output logic        lcd_on_o,
    output logic        busy_o,
    output logic        done_o
);

    // Counter reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [CNT_W-1:0] C_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] C_PULSE = CNT_W'(T_PULSE - 1);
    localparam logic [CNT_W-1:0] C_HOLD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] C_SHORT = CNT_W'(T_WAIT_SHORT - 1);
    localparam logic [CNT_W-1:0] C_LONG  = CNT_W'(T_WAIT_LONG - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_PULSE = 3'd2,
        S_HOLD  = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             req_seen;
    logic             req_pending;
    logic             long_wait;
    logic             unused_bits;

    // A request is a change of the toggle bit relative to the last accepted value.
    assign req_pending = (lcd_word_i[10] != req_seen);

    // Clear-display and return-home commands need the long settle time.
    assign long_wait = !lcd_rs_o && ((lcd_data_o == 8'h01) || (lcd_data_o == 8'h02));

    // The peripheral never reads back from the panel.
    assign lcd_rw_o = 1'b0;

    assign unused_bits = ^{lcd_word_i[30:11], lcd_word_i[8]};

    // Transfer sequencer: the latched bus values double as the output registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state      <= S_IDLE;
            cnt        <= '0;
            lcd_data_o <= 8'h00;
            lcd_rs_o   <= 1'b0;
            lcd_en_o   <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            req_seen   <= lcd_word_i[10];
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_pending) begin
                        lcd_data_o <= lcd_word_i[7:0];
                        lcd_rs_o   <= lcd_word_i[9];
                        req_seen   <= lcd_word_i[10];
                        cnt        <= C_SETUP;
                        busy_o     <= 1'b1;
                        state      <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt == '0) begin
                        cnt      <= C_PULSE;
                        lcd_en_o <= 1'b1;
                        state    <= S_PULSE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_PULSE: begin
                    if (cnt == '0) begin
                        cnt      <= C_HOLD;
                        lcd_en_o <= 1'b0;
                        state    <= S_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (cnt == '0) begin
                        cnt   <= long_wait ? C_LONG : C_SHORT;
                        state <= S_WAIT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    cnt      <= '0;
                    lcd_en_o <= 1'b0;
                    busy_o   <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

    // Power/backlight bit is a plain one-stage copy, independent of transfers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lcd_on_o <= 1'b0;
        end else begin
            lcd_on_o <= lcd_word_i[31];
        end
    end

endmodule

`default_nettype wire
